fnd_scan_controller: RTL and testbench
======================================

# fnd_scan_controller

Time-multiplexed driver for a bank of common-anode seven-segment (FND) digits. It takes a packed word of 4-bit digit codes and scans them onto a shared active-low segment bus with an active-low digit-select bus. Over the plain BCD font decoder it adds a parametrised digit count, a hex mode, per-digit decimal points, leading-zero suppression, an anti-ghosting blank interval and frame-coherent input capture. It sits between the AXI4 register slave and the board FND pins.

## Interface
- NUM_DIGITS, 4, number of scanned digits; legal range 1..8.
- REFRESH_DIV, 100_000, clock cycles per digit slot; must be ≥ 2.
- BLANK_CYCLES, 1_000, cycles at the start of each slot with all digits off; must be < REFRESH_DIV.

- i_clk, input, 1, system clock.
- i_reset, input, 1, synchronous reset, active-high.
- i_en, input, 1, scan enable.
- i_value, input, 4*NUM_DIGITS, digit codes; digit k = i_value[4k+3:4k]; digit 0 is the rightmost (LSD).
- i_dp, input, NUM_DIGITS, decimal point per digit; 1 = lit.
- i_hex_mode, input, 1, 1 = codes A..F are rendered, 0 = codes A..F are blanked.
- i_lz_suppress, input, 1, 1 = blank leading zeros.
- o_font, output, 8, segments a..g on bits 0..6 and dp on bit 7; active-low.
- o_digit_sel, output, NUM_DIGITS, one-hot-low digit enable.

## Operation
- Prescaler cnt counts 0..REFRESH_DIV-1 while i_en=1, then wraps to 0. Index idx advances (idx+1) mod NUM_DIGITS on the cycle where cnt = REFRESH_DIV-1.
- Frame snapshot registers hold value, dp, hex_mode and lz_suppress. They load from the inputs:
  - on the first enabled cycle after reset;
  - on the cycle where cnt = REFRESH_DIV-1 and idx = NUM_DIGITS-1, i.e. at the frame wrap.
  - Input changes mid-frame never show before the next frame.
- Font codes:
  - 0..9 → C0 F9 A4 B0 99 92 82 F8 80 98.
  - Hex mode, A..F → 88 83 C6 A1 86 8E.
  - A..F with hex mode off → FF.
- Leading-zero suppression: scanning from digit NUM_DIGITS-1 downward, every code-0 digit above the first nonzero digit renders FF. Digit 0 is never suppressed, so all-zero input shows a single 0.
- Decimal point: if the snapshot dp[idx]=1, bit 7 of the font is cleared. This also applies to blanked or suppressed digits.
- Slot phases:
  - While cnt < BLANK_CYCLES: o_digit_sel = all ones and o_font = FF.
  - Otherwise: o_digit_sel has bit idx low and all other bits high, and o_font = the rendered font.
- Suppressed digits are still selected with font FF, which keeps the duty cycle uniform across digits.
- i_en=0: cnt and idx hold, and the outputs go to the blank state. On re-enable, scanning resumes from the held cnt and idx.

## Timing
- Reset values: cnt=0, idx=0, snapshot=0, o_digit_sel = all ones, o_font = 8'hFF. The snapshot load-pending flag is set.
- All outputs are registered, with 1-cycle latency from cnt and idx state to the pins.
- Reset asserted mid-slot: the outputs return to their reset values on the next edge. No partial slot completes.
- i_en falling: the outputs are blank on the next edge. i_en rising: the outputs reflect the held cnt on the next edge.
- Frame period is NUM_DIGITS*REFRESH_DIV cycles. Each digit is lit for REFRESH_DIV-BLANK_CYCLES cycles per frame.
- NUM_DIGITS=1: idx stays 0, and the snapshot reloads every REFRESH_DIV cycles.

## Structure
- Package fnd_pkg holds:
  - the font constants FONT_0..FONT_F;
  - FONT_BLANK = 8'hFF;
  - DP_BIT = 7.
- Sub-module fnd_font_lut is combinational: 4-bit code plus hex_en in, 8-bit font out, no dp handling. The top-level instantiates it once, on the snapshot digit at idx.
- The top-level contains the prescaler, idx, snapshot, leading-zero mask, dp merge and output registers.

## Test plan
All scenarios use NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.
- Reset: assert i_reset for 3 cycles with i_en=1 → o_digit_sel=4'b1111 and o_font=8'hFF. The first o_digit_sel=4'b1110 appears on the 3rd edge after release and stays for 6 cycles.
- i_value=16'h1234, dp, hex and lz all 0 → per slot: sel 1110/99, 1101/B0, 1011/A4, 0111/F9. Blank for 2 cycles at the start of each slot. Frame length 32 cycles.
- lz=1, i_value=16'h0007 → digits 3..1 show FF and digit 0 shows F8. i_value=16'h0000 → digits 3..1 show FF and digit 0 shows C0. i_value=16'h0400 → digit 3 shows FF; digits 2, 1, 0 show 99, C0, C0.
- i_value=16'hABCD with hex=1 → digits 0..3 show A1, C6, 83, 88. The same value with hex=0 → all FF.
- Snapshot coherence: i_value=16'h1234, then write 16'h5678 while idx=1 → digits 2 and 3 still show A4 and F9 in that frame. The next frame shows digits 0..3 as 80, F8, 82, 92.
- dp and enable, with i_value=16'h1234:
  - i_dp=4'b0010 → digit 1 shows 8'h30.
  - Drop i_en for 5 cycles mid-slot → outputs blank from the next edge, and cnt and idx frozen.
  - Re-enable → the same digit resumes with its remaining slot cycles.

Source files
------------

// File: rtl/fnd_pkg.sv
// Shared constants for the seven-segment scan controller.
// Fonts are active-low: segments a..g on bits 0..6, dp on bit 7.
package fnd_pkg;

  localparam int unsigned CODE_W = 4;
  localparam int unsigned FONT_W = 8;
  localparam int unsigned DP_BIT = 7;

  localparam logic [FONT_W-1:0] FONT_0     = 8'hC0;
  localparam logic [FONT_W-1:0] FONT_1     = 8'hF9;
  localparam logic [FONT_W-1:0] FONT_2     = 8'hA4;
  localparam logic [FONT_W-1:0] FONT_3     = 8'hB0;
  localparam logic [FONT_W-1:0] FONT_4     = 8'h99;
  localparam logic [FONT_W-1:0] FONT_5     = 8'h92;
  localparam logic [FONT_W-1:0] FONT_6     = 8'h82;
  localparam logic [FONT_W-1:0] FONT_7     = 8'hF8;
  localparam logic [FONT_W-1:0] FONT_8     = 8'h80;
  localparam logic [FONT_W-1:0] FONT_9     = 8'h98;
  localparam logic [FONT_W-1:0] FONT_A     = 8'h88;
  localparam logic [FONT_W-1:0] FONT_B     = 8'h83;
  localparam logic [FONT_W-1:0] FONT_C     = 8'hC6;
  localparam logic [FONT_W-1:0] FONT_D     = 8'hA1;
  localparam logic [FONT_W-1:0] FONT_E     = 8'h86;
  localparam logic [FONT_W-1:0] FONT_F     = 8'h8E;
  localparam logic [FONT_W-1:0] FONT_BLANK = 8'hFF;

endpackage

// File: rtl/fnd_font_lut.sv
// Combinational 4-bit code to active-low segment font (no dp handling).
// Ports: i_code  - digit code 0..F
//        i_hex_en - 1 renders A..F, 0 blanks them
//        o_font_c - active-low font, dp bit always 1
module fnd_font_lut
  import fnd_pkg::*;
(
  input  logic [CODE_W-1:0] i_code,
  input  logic              i_hex_en,
  output logic [FONT_W-1:0] o_font_c
);

  always_comb begin
    o_font_c = FONT_BLANK;
    case (i_code)
      4'h0: o_font_c = FONT_0;
      4'h1: o_font_c = FONT_1;
      4'h2: o_font_c = FONT_2;
      4'h3: o_font_c = FONT_3;
      4'h4: o_font_c = FONT_4;
      4'h5: o_font_c = FONT_5;
      4'h6: o_font_c = FONT_6;
      4'h7: o_font_c = FONT_7;
      4'h8: o_font_c = FONT_8;
      4'h9: o_font_c = FONT_9;
      4'hA: if (i_hex_en) o_font_c = FONT_A;
      4'hB: if (i_hex_en) o_font_c = FONT_B;
      4'hC: if (i_hex_en) o_font_c = FONT_C;
      4'hD: if (i_hex_en) o_font_c = FONT_D;
      4'hE: if (i_hex_en) o_font_c = FONT_E;
      4'hF: if (i_hex_en) o_font_c = FONT_F;
    endcase
  end

endmodule

// File: rtl/fnd_scan_controller.sv
// Time-multiplexed common-anode seven-segment scanner.
// Ports: i_clk/i_reset (sync, active-high), i_en scan enable,
//        i_value packed 4-bit codes (digit 0 = LSD), i_dp per-digit dp,
//        i_hex_mode, i_lz_suppress,
//        o_font active-low segments+dp, o_digit_sel one-hot-low select.
module fnd_scan_controller
  import fnd_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned REFRESH_DIV  = 100_000,
  parameter int unsigned BLANK_CYCLES = 1_000
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic                           i_en,
  input  logic [CODE_W*NUM_DIGITS-1:0]   i_value,
  input  logic [NUM_DIGITS-1:0]          i_dp,
  input  logic                           i_hex_mode,
  input  logic                           i_lz_suppress,
  output logic [FONT_W-1:0]              o_font,
  output logic [NUM_DIGITS-1:0]          o_digit_sel
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned VAL_W = CODE_W * NUM_DIGITS;

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [VAL_W-1:0]      value_q, value_d;
  logic [NUM_DIGITS-1:0] dp_q, dp_d;
  logic                  hex_q, hex_d;
  logic                  lz_q, lz_d;
  logic                  pending_q, pending_d;
  logic [FONT_W-1:0]     font_q, font_d;
  logic [NUM_DIGITS-1:0] sel_q, sel_d;

  logic [CODE_W-1:0]     code_c;
  logic                  dp_c;
  logic                  supp_c;
  logic [NUM_DIGITS-1:0] lz_mask_c;
  logic [FONT_W-1:0]     lut_font_c;
  logic [FONT_W-1:0]     lit_font_c;
  logic                  slot_end_c;
  logic                  last_idx_c;

  // Leading-zero mask from the MSD down; digit 0 is never masked.
  always_comb begin
    logic nz_seen;
    nz_seen   = 1'b0;
    lz_mask_c = '0;
    for (int k = int'(NUM_DIGITS) - 1; k > 0; k--) begin
      if (value_q[CODE_W*k +: CODE_W] != '0) nz_seen = 1'b1;
      lz_mask_c[k] = lz_q & ~nz_seen;
    end
  end

  // Pick the snapshot digit, dp and mask bit for the current slot.
  always_comb begin
    code_c = '0;
    dp_c   = 1'b0;
    supp_c = 1'b0;
    for (int k = 0; k < int'(NUM_DIGITS); k++) begin
      if (idx_q == IDX_W'(k)) begin
        code_c = value_q[CODE_W*k +: CODE_W];
        dp_c   = dp_q[k];
        supp_c = lz_mask_c[k];
      end
    end
  end

  fnd_font_lut u_font_lut (
    .i_code   (code_c),
    .i_hex_en (hex_q),
    .o_font_c (lut_font_c)
  );

  // dp is merged after suppression so blanked digits can still show it.
  always_comb begin
    lit_font_c = supp_c ? FONT_BLANK : lut_font_c;
    if (dp_c) lit_font_c[DP_BIT] = 1'b0;
  end

  // Prescaler, digit index, frame snapshot and registered outputs.
  always_comb begin
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    value_d   = value_q;
    dp_d      = dp_q;
    hex_d     = hex_q;
    lz_d      = lz_q;
    pending_d = pending_q;
    font_d    = FONT_BLANK;
    sel_d     = '1;

    slot_end_c = (cnt_q == CNT_W'(REFRESH_DIV - 1));
    last_idx_c = (idx_q == IDX_W'(NUM_DIGITS - 1));

    if (i_en) begin
      cnt_d = slot_end_c ? '0 : cnt_q + CNT_W'(1);
      if (slot_end_c) idx_d = last_idx_c ? '0 : idx_q + IDX_W'(1);

      if (pending_q || (slot_end_c && last_idx_c)) begin
        value_d   = i_value;
        dp_d      = i_dp;
        hex_d     = i_hex_mode;
        lz_d      = i_lz_suppress;
        pending_d = 1'b0;
      end

      if (cnt_q >= CNT_W'(BLANK_CYCLES)) begin
        sel_d  = ~(NUM_DIGITS'(1) << idx_q);
        font_d = lit_font_c;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      value_q   <= '0;
      dp_q      <= '0;
      hex_q     <= 1'b0;
      lz_q      <= 1'b0;
      pending_q <= 1'b1;
      font_q    <= FONT_BLANK;
      sel_q     <= '1;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      value_q   <= value_d;
      dp_q      <= dp_d;
      hex_q     <= hex_d;
      lz_q      <= lz_d;
      pending_q <= pending_d;
      font_q    <= font_d;
      sel_q     <= sel_d;
    end
  end

  assign o_font      = font_q;
  assign o_digit_sel = sel_q;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Directed bench for fnd_scan_controller with NUM_DIGITS=4, REFRESH_DIV=8,
// BLANK_CYCLES=2. Edge n (counted from reset release) shows the slot state
// of edge n-1: lit digit ((n-1)/8)%4 when (n-1)%8 >= 2.
module tb_fnd_scan_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] val;
  logic [3:0]  dp;
  logic        hex;
  logic        lz;
  logic [7:0]  font;
  logic [3:0]  sel;

  int n;
  int tests;
  int fails;

  always #5 clk = ~clk;

  fnd_scan_controller #(
    .NUM_DIGITS   (4),
    .REFRESH_DIV  (8),
    .BLANK_CYCLES (2)
  ) dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_en          (en),
    .i_value       (val),
    .i_dp          (dp),
    .i_hex_mode    (hex),
    .i_lz_suppress (lz),
    .o_font        (font),
    .o_digit_sel   (sel)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic goto_n(input int t);
    while (n < t) tick();
  endtask

  task automatic check_out(input string tag, input logic [3:0] esel, input logic [7:0] efont);
    check({tag, "_sel"}, 16'(sel), 16'(esel));
    check({tag, "_font"}, 16'(font), 16'(efont));
  endtask

  // Middle of the lit part of digit d in frame f.
  task automatic chk_slot(input string tag, input int f, input int d, input logic [7:0] efont);
    logic [3:0] esel;
    esel = ~(4'b0001 << d);
    goto_n(32*f + 8*d + 5);
    check_out(tag, esel, efont);
  endtask

  initial begin
    n     = 0;
    tests = 0;
    fails = 0;
    rst   = 1'b1;
    en    = 1'b1;
    val   = 16'h1234;
    dp    = 4'b0000;
    hex   = 1'b0;
    lz    = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_out("reset", 4'b1111, 8'hFF);
    rst = 1'b0;
    n   = 0;

    // Start-up latency and blank phase
    tick(); check_out("e1_blank", 4'b1111, 8'hFF);
    tick(); check_out("e2_blank", 4'b1111, 8'hFF);
    tick(); check_out("e3_first", 4'b1110, 8'h99);
    goto_n(8);  check_out("e8_last_lit", 4'b1110, 8'h99);
    goto_n(9);  check_out("e9_blank", 4'b1111, 8'hFF);
    goto_n(10); check_out("e10_blank", 4'b1111, 8'hFF);
    goto_n(11); check_out("e11_d1", 4'b1101, 8'hB0);

    // Plain BCD frame 0, frame repeats after 32 cycles
    chk_slot("f0_d2", 0, 2, 8'hA4);
    chk_slot("f0_d3", 0, 3, 8'hF9);
    chk_slot("f1_d0", 1, 0, 8'h99);
    val = 16'h0007; lz = 1'b1;

    // Leading-zero suppression
    chk_slot("lz7_d0", 2, 0, 8'hF8);
    chk_slot("lz7_d1", 2, 1, 8'hFF);
    chk_slot("lz7_d2", 2, 2, 8'hFF);
    chk_slot("lz7_d3", 2, 3, 8'hFF);
    val = 16'h0000;
    chk_slot("lz0_d0", 3, 0, 8'hC0);
    chk_slot("lz0_d1", 3, 1, 8'hFF);
    chk_slot("lz0_d3", 3, 3, 8'hFF);
    val = 16'h0400;
    chk_slot("lz400_d0", 4, 0, 8'hC0);
    chk_slot("lz400_d1", 4, 1, 8'hC0);
    chk_slot("lz400_d2", 4, 2, 8'h99);
    chk_slot("lz400_d3", 4, 3, 8'hFF);
    val = 16'hABCD; lz = 1'b0; hex = 1'b1;

    // Hex mode on/off
    chk_slot("hex_d0", 5, 0, 8'hA1);
    chk_slot("hex_d1", 5, 1, 8'hC6);
    chk_slot("hex_d2", 5, 2, 8'h83);
    chk_slot("hex_d3", 5, 3, 8'h88);
    hex = 1'b0;
    chk_slot("nohex_d0", 6, 0, 8'hFF);
    chk_slot("nohex_d3", 6, 3, 8'hFF);
    val = 16'h1234;

    // Snapshot coherence: change mid-frame at idx=1
    chk_slot("coh_d1", 7, 1, 8'hB0);
    val = 16'h5678;
    chk_slot("coh_d2", 7, 2, 8'hA4);
    chk_slot("coh_d3", 7, 3, 8'hF9);
    chk_slot("new_d0", 8, 0, 8'h80);
    chk_slot("new_d1", 8, 1, 8'hF8);
    chk_slot("new_d2", 8, 2, 8'h82);
    chk_slot("new_d3", 8, 3, 8'h92);
    val = 16'h1234; dp = 4'b0010;

    // Decimal point
    chk_slot("dp_d0", 9, 0, 8'h99);
    chk_slot("dp_d1", 9, 1, 8'h30);

    // Enable drop mid-slot at digit 2 (held cnt=5, idx=2)
    goto_n(309);
    check_out("pre_dis", 4'b1011, 8'hA4);
    en = 1'b0;
    @(posedge clk); #1;
    check_out("dis_1", 4'b1111, 8'hFF);
    repeat (4) @(posedge clk);
    #1;
    check_out("dis_5", 4'b1111, 8'hFF);
    en = 1'b1;
    tick(); check_out("reen_310", 4'b1011, 8'hA4);
    goto_n(312); check_out("reen_312", 4'b1011, 8'hA4);
    goto_n(313); check_out("reen_313_blank", 4'b1111, 8'hFF);
    goto_n(315); check_out("reen_315_d3", 4'b0111, 8'hF9);

    // Reset mid-slot
    goto_n(317);
    rst = 1'b1;
    tick(); check_out("mid_reset", 4'b1111, 8'hFF);
    tick(); check_out("mid_reset_hold", 4'b1111, 8'hFF);
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
